// File: rtl/bw_io_dtl_ctl_pkg.sv
// Shared types and helpers for the DTL edge-logic bank sequencer.
//   state_e  : sequencer state encodings (also driven out on the debug state port)
//   StateW   : width of the state encoding
//   sat_step : saturating add/subtract used for the enable-count ramp
package bw_io_dtl_ctl_pkg;

    localparam int unsigned StateW = 3;

    typedef enum logic [StateW-1:0] {
        StPorHold = 3'd0,
        StOff     = 3'd1,
        StRampUp  = 3'd2,
        StOn      = 3'd3,
        StRampDn  = 3'd4,
        StBsr     = 3'd5
    } state_e;

    // Step cur by delta toward lim (up) or toward zero (down), clamping at the bound.
    function automatic int unsigned sat_step(input int unsigned cur, input int unsigned delta,
                                             input int unsigned lim, input logic up);
        if (up) begin
            return (cur + delta >= lim) ? lim : cur + delta;
        end
        return (cur <= delta) ? 32'd0 : cur - delta;
    endfunction

endpackage

// File: rtl/bw_io_dtl_por_sync.sv
// Power-on reset qualifier for the DTL bank sequencer.
// Samples por_l (one register, or a two-flop synchronizer when BW_IO_DTL_CTL_POR_SYNC_EN is
// defined) and counts POR_DLY cycles of por_l high before declaring power-on complete.
//   clk_i        : bank clock
//   rst_ni       : asynchronous active-low reset
//   por_l_i      : raw power-on reset, active low
//   se_i         : scan enable, freezes the hold counter
//   por_ok_o     : sampled por_l (1 = power good)
//   por_done_o   : power good and hold delay elapsed
module bw_io_dtl_por_sync
    import bw_io_dtl_ctl_pkg::*;
#(
    parameter int unsigned POR_DLY = 16
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic por_l_i,
    input  logic se_i,
    output logic por_ok_o,
    output logic por_done_o
);

    localparam int unsigned CntW = $clog2(POR_DLY + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(POR_DLY - 1);

    logic por_s_q;

`ifdef BW_IO_DTL_CTL_POR_SYNC_EN
    // por_l is asynchronous to clk here; two flops before anything uses it.
    logic por_m_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            por_m_q <= 1'b0;
            por_s_q <= 1'b0;
        end else begin
            por_m_q <= por_l_i;
            por_s_q <= por_m_q;
        end
    end
`else
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            por_s_q <= 1'b0;
        end else begin
            por_s_q <= por_l_i;
        end
    end
`endif

    logic [CntW-1:0] cnt_q, cnt_d;

    // Clears whenever power is not good; saturates once the hold delay is reached.
    always_comb begin
        cnt_d = cnt_q;
        if (!por_s_q) begin
            cnt_d = '0;
        end else if (!se_i && (cnt_q != CntMax)) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign por_ok_o   = por_s_q;
    assign por_done_o = por_s_q && (cnt_q == CntMax);

endmodule

// File: rtl/bw_io_dtl_edge_ctl.sv
// Sequencer for a bank of DTL edge-logic cells: power-on hold, staggered output-enable
// ramp-up/ramp-down, drive-configuration latching and hand-off to boundary scan.
// Optional build macro: BW_IO_DTL_CTL_POR_SYNC_EN (two-flop por_l synchronizer).
//   clk_i, reset_l_i          : bank clock, asynchronous active-low reset
//   por_l_i                   : power-on reset, active low
//   se_i                      : scan enable, freezes the controller (por_l still honoured)
//   oe_req_i, bsr_req_i       : core driver request, boundary-scan ownership request
//   up_open_cfg_i, down_25_cfg_i : requested drive configuration
//   oe_o                      : per-pad output enable
//   sel_bypass_o, bsr_mode_o  : edge-cell clock bypass and boundary-scan mode
//   bsr_gnt_o                 : bank granted to boundary scan
//   up_open_o, down_25_o      : latched drive configuration
//   ready_o                   : all pads enabled, bank on
//   state_o                   : debug view of the sequencer state
module bw_io_dtl_edge_ctl
    import bw_io_dtl_ctl_pkg::*;
#(
    parameter int unsigned NUM_PADS = 8,
    parameter int unsigned GROUP    = 2,
    parameter int unsigned STEP_CYC = 4,
    parameter int unsigned POR_DLY  = 16
) (
    input  logic                clk_i,
    input  logic                reset_l_i,
    input  logic                por_l_i,
    input  logic                se_i,
    input  logic                oe_req_i,
    input  logic                bsr_req_i,
    input  logic                up_open_cfg_i,
    input  logic                down_25_cfg_i,
    output logic [NUM_PADS-1:0] oe_o,
    output logic                sel_bypass_o,
    output logic                bsr_mode_o,
    output logic                bsr_gnt_o,
    output logic                up_open_o,
    output logic                down_25_o,
    output logic                ready_o,
    output logic [StateW-1:0]   state_o
);

    localparam int unsigned CntW  = $clog2(NUM_PADS + 1);
    localparam int unsigned StepW = $clog2(STEP_CYC + 1);
    localparam logic [CntW-1:0]  CntFull  = CntW'(NUM_PADS);
    localparam logic [StepW-1:0] StepLast = StepW'(STEP_CYC - 1);

    // Requests and configuration are sampled once; the FSM acts on the sampled copies.
    logic oe_req_q, bsr_req_q, up_cfg_q, dn_cfg_q;

    always_ff @(posedge clk_i or negedge reset_l_i) begin
        if (!reset_l_i) begin
            oe_req_q  <= 1'b0;
            bsr_req_q <= 1'b0;
            up_cfg_q  <= 1'b0;
            dn_cfg_q  <= 1'b0;
        end else begin
            oe_req_q  <= oe_req_i;
            bsr_req_q <= bsr_req_i;
            up_cfg_q  <= up_open_cfg_i;
            dn_cfg_q  <= down_25_cfg_i;
        end
    end

    logic por_ok, por_done;

    bw_io_dtl_por_sync #(
        .POR_DLY (POR_DLY)
    ) u_por_sync (
        .clk_i      (clk_i),
        .rst_ni     (reset_l_i),
        .por_l_i    (por_l_i),
        .se_i       (se_i),
        .por_ok_o   (por_ok),
        .por_done_o (por_done)
    );

    state_e          state_q, state_d;
    logic [CntW-1:0]  en_q, en_d;
    logic [StepW-1:0] step_q, step_d;
    logic            up_open_q, up_open_d;
    logic            down_25_q, down_25_d;

    logic [CntW-1:0] en_up, en_dn;
    assign en_up = CntW'(sat_step(32'(en_q), GROUP, NUM_PADS, 1'b1));
    assign en_dn = CntW'(sat_step(32'(en_q), GROUP, NUM_PADS, 1'b0));

    always_comb begin
        state_d   = state_q;
        en_d      = en_q;
        step_d    = step_q;
        up_open_d = up_open_q;
        down_25_d = down_25_q;
        if (!por_ok) begin
            // Power abort wins over scan freeze and every request.
            state_d = StPorHold;
            en_d    = '0;
            step_d  = '0;
        end else if (!se_i) begin
            unique case (state_q)
                StPorHold: begin
                    if (por_done) begin
                        state_d = StOff;
                    end
                end
                StOff: begin
                    up_open_d = up_cfg_q;
                    down_25_d = dn_cfg_q;
                    step_d    = '0;
                    if (bsr_req_q) begin
                        state_d = StBsr;
                    end else if (oe_req_q) begin
                        // First group is enabled on the entry edge itself.
                        en_d    = en_up;
                        state_d = (en_up == CntFull) ? StOn : StRampUp;
                    end
                end
                StRampUp: begin
                    if (bsr_req_q || !oe_req_q) begin
                        en_d    = en_dn;
                        step_d  = '0;
                        state_d = (en_dn == '0) ? StOff : StRampDn;
                    end else if (step_q == StepLast) begin
                        en_d   = en_up;
                        step_d = '0;
                        if (en_up == CntFull) begin
                            state_d = StOn;
                        end
                    end else begin
                        step_d = step_q + StepW'(1);
                    end
                end
                StOn: begin
                    if (bsr_req_q || !oe_req_q) begin
                        en_d    = en_dn;
                        step_d  = '0;
                        state_d = (en_dn == '0) ? StOff : StRampDn;
                    end
                end
                StRampDn: begin
                    // Runs to completion; a returning oe_req is served from OFF.
                    if (step_q == StepLast) begin
                        en_d   = en_dn;
                        step_d = '0;
                        if (en_dn == '0) begin
                            state_d = StOff;
                        end
                    end else begin
                        step_d = step_q + StepW'(1);
                    end
                end
                StBsr: begin
                    en_d = '0;
                    if (!bsr_req_q) begin
                        state_d = StOff;
                    end
                end
                default: begin
                    state_d = StPorHold;
                    en_d    = '0;
                    step_d  = '0;
                end
            endcase
        end
    end

    // Outputs are registered from next-state so they move on the same edge as the state.
    logic [NUM_PADS-1:0] oe_d;
    logic sel_bypass_d, bsr_d, ready_d;

    always_comb begin
        oe_d = '0;
        for (int unsigned i = 0; i < NUM_PADS; i++) begin
            oe_d[i] = (i < 32'(en_d));
        end
        sel_bypass_d = (state_d == StPorHold) || (state_d == StOff) || (state_d == StBsr);
        bsr_d        = (state_d == StBsr);
        ready_d      = (state_d == StOn);
    end

    logic [NUM_PADS-1:0] oe_q;
    logic sel_bypass_q, bsr_mode_q, bsr_gnt_q, ready_q;

    always_ff @(posedge clk_i or negedge reset_l_i) begin
        if (!reset_l_i) begin
            state_q      <= StPorHold;
            en_q         <= '0;
            step_q       <= '0;
            up_open_q    <= 1'b0;
            down_25_q    <= 1'b0;
            oe_q         <= '0;
            sel_bypass_q <= 1'b1;
            bsr_mode_q   <= 1'b0;
            bsr_gnt_q    <= 1'b0;
            ready_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            en_q         <= en_d;
            step_q       <= step_d;
            up_open_q    <= up_open_d;
            down_25_q    <= down_25_d;
            oe_q         <= oe_d;
            sel_bypass_q <= sel_bypass_d;
            bsr_mode_q   <= bsr_d;
            bsr_gnt_q    <= bsr_d;
            ready_q      <= ready_d;
        end
    end

    assign oe_o         = oe_q;
    assign sel_bypass_o = sel_bypass_q;
    assign bsr_mode_o   = bsr_mode_q;
    assign bsr_gnt_o    = bsr_gnt_q;
    assign up_open_o    = up_open_q;
    assign down_25_o    = down_25_q;
    assign ready_o      = ready_q;
    assign state_o      = state_q;

endmodule

// File: tb/tb_bw_io_dtl_edge_ctl.sv
// Self-checking bench for bw_io_dtl_edge_ctl (default parameters).
// Expected output values are queued with the cycle they are due when stimulus is driven;
// a negedge monitor pops and compares them as that cycle's outputs appear.
module tb_bw_io_dtl_edge_ctl;

    localparam int unsigned NumPads = 8;
    localparam int unsigned PorDly  = 16;
`ifdef BW_IO_DTL_CTL_POR_SYNC_EN
    localparam int unsigned PorLat = 2;
`else
    localparam int unsigned PorLat = 1;
`endif

    localparam int SelOe = 0, SelState = 1, SelReady = 2, SelByp = 3;
    localparam int SelMode = 4, SelGnt = 5, SelUp = 6, SelDn = 7;

    logic clk = 1'b0;
    logic reset_l, por_l, se, oe_req, bsr_req, up_cfg, dn_cfg;
    logic [NumPads-1:0] oe;
    logic sel_bypass, bsr_mode, bsr_gnt, up_open, down_25, ready;
    logic [2:0] state;

    always #5 clk = ~clk;

    bw_io_dtl_edge_ctl u_dut (
        .clk_i         (clk),
        .reset_l_i     (reset_l),
        .por_l_i       (por_l),
        .se_i          (se),
        .oe_req_i      (oe_req),
        .bsr_req_i     (bsr_req),
        .up_open_cfg_i (up_cfg),
        .down_25_cfg_i (dn_cfg),
        .oe_o          (oe),
        .sel_bypass_o  (sel_bypass),
        .bsr_mode_o    (bsr_mode),
        .bsr_gnt_o     (bsr_gnt),
        .up_open_o     (up_open),
        .down_25_o     (down_25),
        .ready_o       (ready),
        .state_o       (state)
    );

    typedef struct {
        int unsigned at;
        int          sel;
        logic [31:0] val;
        string       tag;
    } exp_t;

    exp_t sb[$];
    int unsigned cyc = 0;
    int unsigned n_chk = 0;
    int unsigned n_err = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic push(input int unsigned at, input int sel, input logic [31:0] val,
                        input string tag);
        exp_t e;
        e.at  = at;
        e.sel = sel;
        e.val = val;
        e.tag = tag;
        sb.push_back(e);
    endtask

    function automatic logic [31:0] obs(input int sel);
        case (sel)
            SelOe:    return 32'(oe);
            SelState: return 32'(state);
            SelReady: return 32'(ready);
            SelByp:   return 32'(sel_bypass);
            SelMode:  return 32'(bsr_mode);
            SelGnt:   return 32'(bsr_gnt);
            SelUp:    return 32'(up_open);
            SelDn:    return 32'(down_25);
            default:  return 32'hdead_beef;
        endcase
    endfunction

    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].at == cyc) begin
                check_eq(sb[i].tag, obs(sb[i].sel), sb[i].val);
                sb.delete(i);
            end
        end
    end

    task automatic tick(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    int unsigned k;

    initial begin
        reset_l = 1'b0; por_l = 1'b0; se = 1'b0; oe_req = 1'b0;
        bsr_req = 1'b0; up_cfg = 1'b0; dn_cfg = 1'b0;

        // Reset values
        tick(2);
        k = cyc;
        push(k + 1, SelState, 0, "rst_state");
        push(k + 1, SelOe,    0, "rst_oe");
        push(k + 1, SelByp,   1, "rst_bypass");
        push(k + 1, SelMode,  0, "rst_bsr_mode");
        push(k + 1, SelGnt,   0, "rst_bsr_gnt");
        push(k + 1, SelUp,    0, "rst_up_open");
        push(k + 1, SelDn,    0, "rst_down_25");
        push(k + 1, SelReady, 0, "rst_ready");
        tick(2);
        reset_l = 1'b1;
        tick(1);

        // Power-on hold: OFF exactly POR_DLY cycles after por_l is seen
        k = cyc;
        por_l = 1'b1;
        push(k + PorLat + PorDly - 1, SelState, 0, "por_still_hold");
        push(k + PorLat + PorDly,     SelState, 1, "por_to_off");
        push(k + PorLat + PorDly,     SelOe,    0, "por_off_oe");
        push(k + PorLat + PorDly,     SelByp,   1, "por_off_bypass");
        tick(PorLat + PorDly + 1);

        // Full ramp-up with defaults (c0 = k+1)
        k = cyc;
        oe_req = 1'b1;
        push(k + 2,  SelOe,    32'h03, "up_c1_oe");
        push(k + 2,  SelState, 2,      "up_c1_state");
        push(k + 2,  SelByp,   0,      "up_c1_bypass");
        push(k + 6,  SelOe,    32'h0f, "up_c5_oe");
        push(k + 9,  SelOe,    32'h0f, "up_c8_oe");
        push(k + 10, SelOe,    32'h3f, "up_c9_oe");
        push(k + 13, SelReady, 0,      "up_c12_ready");
        push(k + 14, SelOe,    32'hff, "up_c13_oe");
        push(k + 14, SelState, 3,      "up_c13_state");
        push(k + 14, SelReady, 1,      "up_c13_ready");
        tick(14);

        // Configuration changes in ON are ignored
        k = cyc;
        up_cfg = 1'b1;
        dn_cfg = 1'b1;
        push(k + 3, SelUp, 0, "on_cfg_up_open");
        push(k + 3, SelDn, 0, "on_cfg_down_25");
        tick(3);

        // oe_req drop from ON: full ramp-down, then configuration loads in OFF
        k = cyc;
        oe_req = 1'b0;
        push(k + 2,  SelState, 4,      "dn_c1_state");
        push(k + 2,  SelOe,    32'h3f, "dn_c1_oe");
        push(k + 2,  SelReady, 0,      "dn_c1_ready");
        push(k + 6,  SelOe,    32'h0f, "dn_c5_oe");
        push(k + 10, SelOe,    32'h03, "dn_c9_oe");
        push(k + 14, SelOe,    32'h00, "dn_c13_oe");
        push(k + 14, SelState, 1,      "dn_c13_state");
        push(k + 14, SelByp,   1,      "dn_c13_bypass");
        push(k + 16, SelUp,    1,      "off_cfg_up_open");
        push(k + 16, SelDn,    1,      "off_cfg_down_25");
        tick(16);

        k = cyc;
        up_cfg = 1'b0;
        push(k + 3, SelUp, 0, "off_cfg_up_follow");
        push(k + 3, SelDn, 1, "off_cfg_dn_hold");
        tick(3);

        // oe_req drops at c6 mid ramp-up; re-assert at c8 must not reverse the ramp-down
        k = cyc;
        oe_req = 1'b1;
        push(k + 2,  SelOe,    32'h03, "abrt_c1_oe");
        push(k + 6,  SelOe,    32'h0f, "abrt_c5_oe");
        push(k + 8,  SelState, 4,      "abrt_c7_state");
        push(k + 8,  SelOe,    32'h03, "abrt_c7_oe");
        push(k + 11, SelState, 4,      "abrt_c10_state");
        push(k + 11, SelOe,    32'h03, "abrt_c10_oe");
        push(k + 12, SelOe,    32'h00, "abrt_c11_oe");
        push(k + 12, SelState, 1,      "abrt_c11_state");
        push(k + 12, SelByp,   1,      "abrt_c11_bypass");
        push(k + 13, SelState, 2,      "reup_state");
        push(k + 13, SelOe,    32'h03, "reup_oe");
        push(k + 25, SelState, 3,      "reup_on_state");
        push(k + 25, SelOe,    32'hff, "reup_on_oe");
        tick(6);
        oe_req = 1'b0;
        tick(2);
        oe_req = 1'b1;
        tick(18);

        // Boundary-scan request in ON: ramp down fully before grant
        k = cyc;
        bsr_req = 1'b1;
        push(k + 2,  SelState, 4,      "bsr_rampdn_state");
        push(k + 13, SelOe,    32'h03, "bsr_c12_oe");
        push(k + 13, SelGnt,   0,      "bsr_c12_gnt");
        push(k + 13, SelMode,  0,      "bsr_c12_mode");
        push(k + 14, SelState, 1,      "bsr_c13_off");
        push(k + 14, SelGnt,   0,      "bsr_c13_gnt");
        push(k + 15, SelState, 5,      "bsr_c14_state");
        push(k + 15, SelGnt,   1,      "bsr_c14_gnt");
        push(k + 15, SelMode,  1,      "bsr_c14_mode");
        push(k + 15, SelOe,    0,      "bsr_c14_oe");
        push(k + 15, SelByp,   1,      "bsr_c14_bypass");
        tick(16);

        k = cyc;
        bsr_req = 1'b0;
        oe_req  = 1'b0;
        push(k + 2, SelState, 1, "bsr_rel_state");
        push(k + 2, SelGnt,   0, "bsr_rel_gnt");
        push(k + 2, SelMode,  0, "bsr_rel_mode");
        tick(3);

        // Scan freeze mid ramp-up, then power abort while frozen
        k = cyc;
        oe_req = 1'b1;
        push(k + 2,  SelOe,    32'h03, "se_c1_oe");
        push(k + 10, SelOe,    32'h03, "se_frozen_oe");
        push(k + 10, SelState, 2,      "se_frozen_state");
        push(k + 10 + PorLat, SelState, 2,      "por_pre_state");
        push(k + 10 + PorLat, SelOe,    32'h03, "por_pre_oe");
        push(k + 11 + PorLat, SelState, 0,      "por_abort_state");
        push(k + 11 + PorLat, SelOe,    0,      "por_abort_oe");
        push(k + 11 + PorLat, SelByp,   1,      "por_abort_bypass");
        tick(3);
        se = 1'b1;
        tick(7);
        por_l = 1'b0;
        tick(PorLat + 2);

        // Recover from the abort
        se     = 1'b0;
        oe_req = 1'b0;
        k = cyc;
        por_l = 1'b1;
        push(k + PorLat + PorDly, SelState, 1, "por_recover_off");
        tick(PorLat + PorDly + 2);

        check_eq("sb_drain", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
